// File: rtl/mem_image_ram.sv
// Single-clock RAM that loads itself from an external image ROM after reset,
// then serves a read/write port A, a read-only port B and a range-clear engine.
module mem_image_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [DATA_W-1:0] img_data,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] clr_base,
  input  logic [ADDR_W:0]   clr_len,
  output logic              busy,
  output logic              ready,
  output logic [1:0]        state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   LAST_P  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_P = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W + 2)'(DEPTH);

  typedef enum logic [1:0] {
    ST_COPY  = 2'd0,
    ST_READY = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W:0]     ptr, ptr_nx;
  logic [ADDR_W:0]     end_q, end_nx;
  logic [ADDR_W+1:0]   clr_sum;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic                a_rd;

  // Handshake: port A (a_en/a_we) and clr_req are taken on a rising edge only
  // while ready=1; with ready=0 they are dropped, never queued or stalled.
  assign clr_sum = (ADDR_W + 2)'(clr_base) + (ADDR_W + 2)'(clr_len);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    end_nx   = end_q;
    we       = 1'b0;
    waddr    = ptr[ADDR_W-1:0];
    wdata    = '0;
    a_rd     = 1'b0;
    case (state)
      ST_COPY: begin
        we     = 1'b1;
        wdata  = img_data;
        ptr_nx = ptr + 1'b1;
        if (ptr == LAST_P) state_nx = ST_READY;
      end
      ST_CLEAR: begin
        we     = 1'b1;
        ptr_nx = ptr + 1'b1;
        if (ptr_nx == end_q) state_nx = ST_READY;
      end
      ST_READY: begin
        a_rd = a_en;
        if (a_en && a_we) begin
          we    = 1'b1;
          waddr = a_addr;
          wdata = a_wdata;
        end
        // Range end saturates at DEPTH so the clear never wraps to address 0.
        if (clr_req && (clr_len != '0)) begin
          state_nx = ST_CLEAR;
          ptr_nx   = {1'b0, clr_base};
          end_nx   = (clr_sum > DEPTH_W) ? DEPTH_P : clr_sum[ADDR_W:0];
        end
      end
      default: state_nx = ST_COPY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_COPY;
      ptr     <= '0;
      end_q   <= '0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      end_q   <= end_nx;
      b_rdata <= mem[b_addr];
      if (a_rd) a_rdata <= mem[a_addr];
    end
  end

  assign busy      = (state != ST_READY);
  assign ready     = ~busy;
  assign img_addr  = ptr[ADDR_W-1:0];
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_image_ram.sv
// Directed bench for mem_image_ram: init copy, port A/B vectors, range clears,
// gating while busy and reset in the middle of a clear.
module tb_mem_image_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] img_addr, img_data;
  logic       a_en, a_we;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic [7:0] b_addr, b_rdata;
  logic       clr_req;
  logic [7:0] clr_base;
  logic [8:0] clr_len;
  logic       busy, ready;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] ref_mem [256];

  typedef struct {
    logic       en;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] baddr;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;
  vec_t vecs [7];

  mem_image_ram #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .img_addr(img_addr), .img_data(img_data),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .b_addr(b_addr), .b_rdata(b_rdata),
    .clr_req(clr_req), .clr_base(clr_base), .clr_len(clr_len),
    .busy(busy), .ready(ready), .state_dbg(state_dbg)
  );

  // clock / ROM model
  always #5 clk = ~clk;
  assign img_data = img_addr ^ 8'hA5;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic en, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata);
    a_en = en; a_we = we; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic scan_b(input string tag);
    for (int k = 0; k < 256; k++) begin
      b_addr = 8'(k);
      step();
      check($sformatf("%s_b[%0d]", tag, k), b_rdata, ref_mem[k]);
    end
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int cnt = 0;
    while (!ready && cnt < 1000) begin
      step();
      cnt++;
    end
    check({tag, "_ready_cycles"}, cnt, exp_cycles);
  endtask

  // Issue a clear and count the cycles busy stays high. With gate=1 the bench
  // also attempts a port A write and a second clr_req while the clear runs.
  task automatic run_clear(input string tag, input logic [7:0] base, input logic [8:0] len,
                           input int exp_busy, input logic gate);
    int cnt = 0;
    clr_req = 1'b1; clr_base = base; clr_len = len;
    step();
    clr_req = 1'b0;
    while (busy && cnt < 100) begin
      cnt++;
      if (gate && cnt == 3) begin
        drive_a(1'b1, 1'b1, 8'h30, 8'hEE);
        clr_req = 1'b1; clr_base = 8'h00; clr_len = 9'd5;
      end
      if (gate && cnt == 20) begin
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        clr_req = 1'b0;
      end
      step();
    end
    check({tag, "_busy_cycles"}, cnt, exp_busy);
    for (int k = 0; k < int'(len); k++)
      if (int'(base) + k < 256) ref_mem[int'(base) + k] = 8'h00;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'd182, 8'h3C, 8'd182, 8'h13, 8'h13};
    vecs[1] = '{1'b1, 1'b0, 8'd182, 8'h00, 8'd182, 8'h3C, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 8'h00,  8'h00, 8'h00,  8'h3C, 8'hA5};
    vecs[3] = '{1'b1, 1'b1, 8'h10,  8'h77, 8'h10,  8'hB5, 8'hB5};
    vecs[4] = '{1'b1, 1'b0, 8'h10,  8'h00, 8'h11,  8'h77, 8'hB4};
    vecs[5] = '{1'b0, 1'b1, 8'h20,  8'hFF, 8'h20,  8'h77, 8'h85};
    vecs[6] = '{1'b1, 1'b0, 8'h20,  8'h00, 8'hFF,  8'h85, 8'h5A};

    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 8'h00, 8'h00);
    b_addr = 8'h00; clr_req = 1'b0; clr_base = 8'h00; clr_len = 9'd0;
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'(k) ^ 8'hA5;

    // reset state
    @(negedge clk);
    step();
    check("rst_a_rdata", a_rdata, 8'h00);
    check("rst_b_rdata", b_rdata, 8'h00);
    check("rst_busy", busy, 1'b1);
    check("rst_ready", ready, 1'b0);
    check("rst_img_addr", img_addr, 8'h00);

    // init copy
    rst_n = 1'b1;
    wait_ready("init", 256);
    scan_b("init");

    // port A / B vectors
    for (int i = 0; i < 7; i++) begin
      drive_a(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      b_addr = vecs[i].baddr;
      step();
      check($sformatf("vec%0d_a_rdata", i), a_rdata, vecs[i].exp_a);
      check($sformatf("vec%0d_b_rdata", i), b_rdata, vecs[i].exp_b);
    end
    drive_a(1'b0, 1'b0, 8'h00, 8'h00);
    ref_mem[182] = 8'h3C;
    ref_mem[16]  = 8'h77;

    // clear 182..214 with a port A write (5 <= 99) in the accept cycle
    drive_a(1'b1, 1'b1, 8'h05, 8'h99);
    ref_mem[5] = 8'h99;
    run_clear("clr182", 8'd182, 9'd33, 33, 1'b1);
    check("clr182_a_rdata_held", a_rdata, 8'hA0);
    scan_b("clr182");

    // truncated clear
    run_clear("clr250", 8'd250, 9'd20, 6, 1'b0);
    scan_b("clr250");

    // zero-length clear is a no-op
    clr_req = 1'b1; clr_base = 8'h00; clr_len = 9'd0;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("noop_busy%0d", i), busy, 1'b0);
      step();
    end

    // reset during clear, then gated port A during the new copy
    b_addr = 8'h10;
    clr_req = 1'b1; clr_base = 8'd100; clr_len = 9'd40;
    step();
    clr_req = 1'b0;
    repeat (9) step();
    check("midclr_busy", busy, 1'b1);
    rst_n = 1'b0;
    step();
    check("midrst_a_rdata", a_rdata, 8'h00);
    check("midrst_b_rdata", b_rdata, 8'h00);
    check("midrst_busy", busy, 1'b1);
    check("midrst_ready", ready, 1'b0);
    check("midrst_img_addr", img_addr, 8'h00);
    rst_n = 1'b1;
    begin
      int cnt = 0;
      while (!ready && cnt < 1000) begin
        if (cnt == 20) drive_a(1'b1, 1'b1, 8'h08, 8'h11);
        if (cnt == 50) begin
          check("copy_a_rdata_held", a_rdata, 8'h00);
          drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        end
        step();
        cnt++;
      end
      check("recopy_ready_cycles", cnt, 256);
    end
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'(k) ^ 8'hA5;
    scan_b("recopy");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
